// File: rtl/qspi_resp.sv
// Target-side quad-SPI responder: oversamples the serial link in clk_i, decodes command/address/
// dummy phases and serves reads/writes from a byte memory. Define QSPI_RESP_SPI_CMD_EN for a
// single-line (qspi_i[0]) command phase.
module qspi_resp #(
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned DUMMY_CYCLES = 6,
  parameter int unsigned ADDR_BITS    = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         qsclk_i,
  input  logic                         qcsb_i,
  input  logic [3:0]                   qspi_i,
  output logic [3:0]                   qspi_o,
  output logic [3:0]                   qspi_oeb,
  input  logic                         bd_we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr_i,
  input  logic [7:0]                   bd_wdata_i,
  output logic [7:0]                   bd_rdata_o,
  output logic                         busy_o,
  output logic [7:0]                   last_cmd_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam logic [7:0] AddrLast  = 8'(ADDR_BITS / 4 - 1);
  localparam logic [7:0] DummyLast = 8'((DUMMY_CYCLES == 0) ? 0 : DUMMY_CYCLES - 1);
`ifdef QSPI_RESP_SPI_CMD_EN
  localparam int unsigned CmdShW  = 7;
  localparam logic [7:0]  CmdLast = 8'd7;
`else
  localparam int unsigned CmdShW  = 4;
  localparam logic [7:0]  CmdLast = 8'd1;
`endif

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StRdata, StWdata, StIgnore
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sclk_sync_q, csb_sync_q;
  logic [3:0]        spi_s1_q, spi_s2_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [CmdShW-1:0] cmd_q, cmd_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              half_q, half_d;
  logic              status_q, status_d;
  logic [3:0]        wnib_q, wnib_d;
  logic [3:0]        qspi_o_q, qspi_o_d;
  logic [3:0]        qspi_oeb_q, qspi_oeb_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic [7:0]        bd_rdata_q;
  logic [7:0]        mem_rdata_q;
  logic [7:0]        mem [MEM_DEPTH];

  logic              sclk_rise, sclk_fall, csb_high, csb_fall;
  logic [7:0]        cmd_shift, cnt_inc, rd_byte;
  logic [AW-1:0]     addr_inc;
  logic              ser_we;

  // Synchronisers are deliberately not reset so a reset mid-frame cannot fake a qcsb fall.
  always_ff @(posedge clk_i) begin
    sclk_sync_q <= {sclk_sync_q[1:0], qsclk_i};
    csb_sync_q  <= {csb_sync_q[1:0], qcsb_i};
    spi_s1_q    <= qspi_i;
    spi_s2_q    <= spi_s1_q;
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign csb_high  = csb_sync_q[1];
  assign csb_fall  = ~csb_sync_q[1] & csb_sync_q[2];

`ifdef QSPI_RESP_SPI_CMD_EN
  assign cmd_shift = {cmd_q, spi_s2_q[0]};
`else
  assign cmd_shift = {cmd_q, spi_s2_q};
`endif
  assign cnt_inc  = cnt_q + 8'd1;
  assign addr_inc = addr_q + AW'(1);
  assign rd_byte  = status_q ? 8'h00 : mem_rdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    half_d     = half_q;
    status_d   = status_q;
    wnib_d     = wnib_q;
    qspi_o_d   = qspi_o_q;
    qspi_oeb_d = qspi_oeb_q;
    last_cmd_d = last_cmd_q;
    ser_we     = 1'b0;

    if (csb_high) begin
      state_d    = StIdle;
      qspi_oeb_d = 4'hF;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d    = '0;
          half_d   = 1'b0;
          status_d = 1'b0;
          if (csb_fall) state_d = StCmd;
        end
        StCmd: begin
          if (sclk_rise) begin
            cmd_d = cmd_shift[CmdShW-1:0];
            cnt_d = cnt_inc;
            if (cnt_q == CmdLast) begin
              last_cmd_d = cmd_shift;
              cnt_d      = '0;
              case (cmd_shift)
                8'hEB, 8'h38: state_d = StAddr;
                8'h05: begin
                  status_d = 1'b1;
                  state_d  = StRdata;
                end
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (sclk_rise) begin
            addr_d = AW'({addr_q, spi_s2_q});
            cnt_d  = cnt_inc;
            if (cnt_q == AddrLast) begin
              cnt_d = '0;
              if (last_cmd_q == 8'h38) state_d = StWdata;
              else if (DUMMY_CYCLES == 0) state_d = StRdata;
              else state_d = StDummy;
            end
          end
        end
        StDummy: begin
          if (sclk_rise) begin
            cnt_d = cnt_inc;
            if (cnt_q == DummyLast) begin
              cnt_d   = '0;
              state_d = StRdata;
            end
          end
        end
        StRdata: begin
          // mem_rdata_q follows addr_q a cycle later, long before the next high nibble is due.
          if (sclk_fall) begin
            qspi_oeb_d = 4'h0;
            half_d     = ~half_q;
            if (!half_q) begin
              qspi_o_d = rd_byte[7:4];
            end else begin
              qspi_o_d = rd_byte[3:0];
              if (!status_q) addr_d = addr_inc;
            end
          end
        end
        StWdata: begin
          if (sclk_rise) begin
            half_d = ~half_q;
            if (!half_q) begin
              wnib_d = spi_s2_q;
            end else begin
              ser_we = 1'b1;
              addr_d = addr_inc;
            end
          end
        end
        StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      half_q     <= 1'b0;
      status_q   <= 1'b0;
      wnib_q     <= '0;
      qspi_o_q   <= 4'h0;
      qspi_oeb_q <= 4'hF;
      last_cmd_q <= 8'h00;
      bd_rdata_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      half_q     <= half_d;
      status_q   <= status_d;
      wnib_q     <= wnib_d;
      qspi_o_q   <= qspi_o_d;
      qspi_oeb_q <= qspi_oeb_d;
      last_cmd_q <= last_cmd_d;
      bd_rdata_q <= mem[bd_addr_i];
    end
  end

  // Serial write is issued after the backdoor write so it wins on an address collision.
  always_ff @(posedge clk_i) begin
    if (bd_we_i) mem[bd_addr_i] <= bd_wdata_i;
    if (ser_we)  mem[addr_q]    <= {wnib_q, spi_s2_q};
    mem_rdata_q <= mem[addr_q];
  end

  assign qspi_o     = qspi_o_q;
  assign qspi_oeb   = qspi_oeb_q;
  assign bd_rdata_o = bd_rdata_q;
  assign busy_o     = (state_q != StIdle);
  assign last_cmd_o = last_cmd_q;

endmodule

// File: tb/tb_qspi_resp.sv
// Scoreboard bench for qspi_resp: an initiator model drives frames, expected values are queued
// from a flat memory model, and a monitor process pairs them with captured DUT observations.
module tb_qspi_resp;
  localparam int MEM_DEPTH = 256;
  localparam int DUMMY     = 6;
  localparam int HALF      = 60;

  logic       clk = 1'b0, rst = 1'b1, qsclk = 1'b0, qcsb = 1'b1;
  logic [3:0] qspi_i = 4'h0;
  logic [3:0] qspi_o, qspi_oeb;
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'h00, bd_wdata = 8'h00;
  logic [7:0] bd_rdata, last_cmd;
  logic       busy;

  always #5 clk = ~clk;

  qspi_resp #(.MEM_DEPTH(MEM_DEPTH), .DUMMY_CYCLES(DUMMY), .ADDR_BITS(24)) dut (
    .clk_i(clk), .rst_i(rst), .qsclk_i(qsclk), .qcsb_i(qcsb), .qspi_i(qspi_i),
    .qspi_o(qspi_o), .qspi_oeb(qspi_oeb), .bd_we_i(bd_we), .bd_addr_i(bd_addr),
    .bd_wdata_i(bd_wdata), .bd_rdata_o(bd_rdata), .busy_o(busy), .last_cmd_o(last_cmd)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
    logic [7:0] mask;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] act_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] model_mem [MEM_DEPTH];

  function automatic void push_exp(input string nm, input logic [7:0] v, input logic [7:0] m);
    exp_t e;
    e.name = nm;
    e.val  = v;
    e.mask = m;
    exp_q.push_back(e);
  endfunction

  initial begin : monitor
    exp_t       e;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      while (act_q.size() > 0) begin
        a = act_q.pop_front();
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL orphan_obs: got %h, no expectation queued", a);
        end else begin
          e = exp_q.pop_front();
          if ((a & e.mask) === (e.val & e.mask)) n_pass++;
          else $display("FAIL %s: got %h want %h (mask %h)", e.name, a, e.val, e.mask);
        end
      end
    end
  end

  // One qsclk period: fall + drive, half period, capture, rise, half period.
  task automatic qcycle(input logic [3:0] nib, input logic rd, input logic [3:0] exp_nib,
                        input string nm);
    qsclk  = 1'b0;
    qspi_i = nib;
    if (rd) push_exp(nm, {4'h0, exp_nib}, 8'hFF);
    else push_exp({nm, "_oeb"}, 8'hF0, 8'hF0);
    #(HALF);
    act_q.push_back({qspi_oeb, qspi_o});
    qsclk = 1'b1;
    #(HALF);
  endtask

  task automatic start_frame();
    qcsb = 1'b0;
    #(HALF);
  endtask

  task automatic end_frame();
    qsclk = 1'b0;
    #(HALF);
    qcsb = 1'b1;
    #(HALF * 2);
  endtask

  task automatic send_cmd(input logic [7:0] c);
`ifdef QSPI_RESP_SPI_CMD_EN
    for (int i = 7; i >= 0; i--) qcycle({3'b000, c[i]}, 1'b0, 4'h0, "cmd");
`else
    qcycle(c[7:4], 1'b0, 4'h0, "cmd");
    qcycle(c[3:0], 1'b0, 4'h0, "cmd");
`endif
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) qcycle(a[i*4 +: 4], 1'b0, 4'h0, "addr");
  endtask

  task automatic send_dummy();
    repeat (DUMMY) qcycle(4'($urandom), 1'b0, 4'h0, "dummy");
  endtask

  task automatic read_bytes(input logic [23:0] a, input int n, input logic status);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = status ? 8'h00 : model_mem[(int'(a) + k) % MEM_DEPTH];
      qcycle(4'($urandom), 1'b1, b[7:4], "rd_hi");
      qcycle(4'($urandom), 1'b1, b[3:0], "rd_lo");
    end
  endtask

  task automatic write_byte(input int idx, input logic [7:0] b);
    model_mem[idx % MEM_DEPTH] = b;
    qcycle(b[7:4], 1'b0, 4'h0, "wr");
    qcycle(b[3:0], 1'b0, 4'h0, "wr");
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bd_we    = 1'b1;
    bd_addr  = a;
    bd_wdata = b;
    model_mem[a] = b;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_check(input int a, input string nm);
    @(negedge clk);
    bd_addr = 8'(a);
    push_exp(nm, model_mem[a % MEM_DEPTH], 8'hFF);
    @(negedge clk);
    act_q.push_back(bd_rdata);
  endtask

  task automatic check_last(input logic [7:0] c);
    push_exp("last_cmd", c, 8'hFF);
    act_q.push_back(last_cmd);
  endtask

  task automatic read_frame(input logic [23:0] a, input int n);
    start_frame();
    send_cmd(8'hEB);
    send_addr(a);
    send_dummy();
    read_bytes(a, n, 1'b0);
    end_frame();
    check_last(8'hEB);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0]  c, old;
    logic [23:0] a;
    int          n, kind;

    repeat (5) @(negedge clk);
    push_exp("rst_oeb_o", 8'hF0, 8'hFF);
    act_q.push_back({qspi_oeb, qspi_o});
    push_exp("rst_busy", 8'h00, 8'hFF);
    act_q.push_back({7'd0, busy});
    check_last(8'h00);
    push_exp("rst_bd_rdata", 8'h00, 8'hFF);
    act_q.push_back(bd_rdata);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < MEM_DEPTH; i++) bd_write(8'(i), 8'($urandom));
    bd_write(8'h10, 8'hAB);
    bd_write(8'h11, 8'hCD);

    read_frame(24'h000010, 2);

    start_frame();
    send_cmd(8'h38);
    send_addr(24'h000020);
    write_byte(32'h20, 8'h12);
    write_byte(32'h21, 8'h34);
    end_frame();
    check_last(8'h38);
    bd_check(32'h20, "wr_20");
    bd_check(32'h21, "wr_21");

    start_frame();
    send_cmd(8'h38);
    send_addr(24'h0000FF);
    write_byte(32'hFF, 8'h5A);
    write_byte(32'h100, 8'hA5);
    end_frame();
    bd_check(32'hFF, "wrap_ff");
    bd_check(32'h00, "wrap_00");

    // Trailing lone nibble must be dropped.
    start_frame();
    send_cmd(8'h38);
    send_addr(24'h000040);
    write_byte(32'h40, 8'h77);
    qcycle(4'h9, 1'b0, 4'h0, "wr_partial");
    end_frame();
    bd_check(32'h40, "partial_40");
    bd_check(32'h41, "partial_41");

    // Abort in the address phase, then a clean read.
    start_frame();
    send_cmd(8'h38);
    for (int i = 5; i >= 3; i--) qcycle(4'h3, 1'b0, 4'h0, "addr");
    push_exp("busy_mid", 8'h01, 8'hFF);
    act_q.push_back({7'd0, busy});
    qcsb = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    push_exp("busy_drop", 8'h00, 8'hFF);
    act_q.push_back({7'd0, busy});
    qsclk = 1'b0;
    #(HALF * 2);
    bd_check(32'h33, "abort_33");
    read_frame(24'h000010, 1);

    start_frame();
    send_cmd(8'h9F);
    repeat (8) qcycle(4'($urandom), 1'b0, 4'h0, "ign");
    end_frame();
    check_last(8'h9F);
    bd_check(32'h10, "ign_10");
    bd_check(32'h11, "ign_11");

    // Reset in the middle of read data.
    start_frame();
    send_cmd(8'hEB);
    send_addr(24'h000010);
    send_dummy();
    read_bytes(24'h000010, 1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_exp("rst_mid_oeb", 8'hF0, 8'hF0);
    act_q.push_back({qspi_oeb, qspi_o});
    push_exp("rst_mid_busy", 8'h00, 8'hFF);
    act_q.push_back({7'd0, busy});
    rst = 1'b0;
    repeat (4) qcycle(4'($urandom), 1'b0, 4'h0, "post_rst");
    end_frame();
    check_last(8'h00);
    read_frame(24'h000011, 1);

    for (int r = 0; r < 24; r++) begin
      kind = int'($urandom_range(0, 3));
      a    = 24'($urandom);
      n    = int'($urandom_range(1, 4));
      case (kind)
        0: read_frame(a, n);
        1: begin
          start_frame();
          send_cmd(8'h38);
          send_addr(a);
          for (int k = 0; k < n; k++) write_byte(int'(a) + k, 8'($urandom));
          end_frame();
          check_last(8'h38);
          for (int k = 0; k < n; k++) bd_check((int'(a) + k) % MEM_DEPTH, "rnd_wr");
        end
        2: begin
          start_frame();
          send_cmd(8'h05);
          read_bytes(24'h0, n, 1'b1);
          end_frame();
          check_last(8'h05);
        end
        default: begin
          do c = 8'($urandom); while (c == 8'hEB || c == 8'h38 || c == 8'h05);
          start_frame();
          send_cmd(c);
          repeat (n * 2) qcycle(4'($urandom), 1'b0, 4'h0, "rnd_ign");
          end_frame();
          check_last(c);
        end
      endcase
    end

    // Backdoor read during a backdoor write returns the old byte.
    @(negedge clk);
    old      = model_mem[8'h50];
    bd_we    = 1'b1;
    bd_addr  = 8'h50;
    bd_wdata = ~old;
    model_mem[8'h50] = ~old;
    push_exp("bd_rd_old", old, 8'hFF);
    @(negedge clk);
    act_q.push_back(bd_rdata);
    bd_we = 1'b0;
    bd_check(32'h50, "bd_rd_new");

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover: got %0d unmatched expectations want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
